// File: rtl/sdram_cfg_master.sv
// Wishbone master that replays a fixed ten-write CSR bring-up sequence into the
// SDRAM controller on each go pulse, with a per-write ack timeout.
module sdram_cfg_master #(
  parameter int unsigned AW         = 16,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] OPMODE_VAL = 32'h0000_0230,
  parameter logic [31:0] CONFIG_VAL = 32'h0,
  parameter logic [31:0] TDLY_VAL   = 32'd10000,
  parameter logic [31:0] TRCD_VAL   = 32'd2,
  parameter logic [31:0] TRFC_VAL   = 32'd7,
  parameter logic [31:0] TREF_VAL   = 32'd782,
  parameter logic [31:0] TRP_VAL    = 32'd2,
  parameter logic [31:0] TWRP_VAL   = 32'd2,
  parameter logic [31:0] TMRD_VAL   = 32'd2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  output logic [AW-1:0] wbm_address,
  output logic [31:0]   wbm_writedata,
  output logic          wbm_strobe,
  output logic          wbm_cycle,
  output logic          wbm_write,
  input  logic          wbm_ack,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [3:0]    err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd9;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic [3:0] idx_q;
  logic [7:0] tmo_q;

  function automatic logic [AW-1:0] addr_of(input logic [3:0] i);
    logic [7:0] a;
    case (i)
      4'd0:    a = 8'h04;
      4'd1:    a = 8'h08;
      4'd2:    a = 8'h0c;
      4'd3:    a = 8'h10;
      4'd4:    a = 8'h14;
      4'd5:    a = 8'h18;
      4'd6:    a = 8'h1c;
      4'd7:    a = 8'h20;
      4'd8:    a = 8'h24;
      default: a = 8'h00;
    endcase
    return AW'(a);
  endfunction

  function automatic logic [31:0] data_of(input logic [3:0] i);
    logic [31:0] d;
    case (i)
      4'd0:    d = OPMODE_VAL;
      4'd1:    d = CONFIG_VAL;
      4'd2:    d = TDLY_VAL;
      4'd3:    d = TRCD_VAL;
      4'd4:    d = TRFC_VAL;
      4'd5:    d = TREF_VAL;
      4'd6:    d = TRP_VAL;
      4'd7:    d = TWRP_VAL;
      4'd8:    d = TMRD_VAL;
      4'd9:    d = 32'h1;
      default: d = '0;
    endcase
    return d;
  endfunction

  // Address/data are loaded only when entering REQ, so they hold through GAP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      tmo_q         <= '0;
      wbm_address   <= '0;
      wbm_writedata <= '0;
      wbm_strobe    <= 1'b0;
      wbm_cycle     <= 1'b0;
      wbm_write     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_idx       <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (go) begin
            state_q       <= S_REQ;
            idx_q         <= '0;
            tmo_q         <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_idx       <= '0;
            busy          <= 1'b1;
            wbm_strobe    <= 1'b1;
            wbm_cycle     <= 1'b1;
            wbm_write     <= 1'b1;
            wbm_address   <= addr_of(4'd0);
            wbm_writedata <= data_of(4'd0);
          end
        end
        S_REQ: begin
          if (wbm_ack) begin
            state_q    <= S_GAP;
            wbm_strobe <= 1'b0;
            wbm_cycle  <= 1'b0;
            wbm_write  <= 1'b0;
          end else if (tmo_q == TMO_LAST) begin
            state_q    <= S_ERR;
            err        <= 1'b1;
            err_idx    <= idx_q;
            busy       <= 1'b0;
            wbm_strobe <= 1'b0;
            wbm_cycle  <= 1'b0;
            wbm_write  <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_GAP: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state_q       <= S_REQ;
            idx_q         <= idx_q + 4'd1;
            tmo_q         <= '0;
            wbm_strobe    <= 1'b1;
            wbm_cycle     <= 1'b1;
            wbm_write     <= 1'b1;
            wbm_address   <= addr_of(idx_q + 4'd1);
            wbm_writedata <= data_of(idx_q + 4'd1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cfg_master.sv
// Self-checking bench for sdram_cfg_master: records a per-cycle bus trace and
// compares it against write start cycles computed from slave latencies.
module tb_sdram_cfg_master;
  localparam int AW   = 16;
  localparam int TMO  = 16;
  localparam int MAXC = 400;

  logic          clk = 1'b0;
  logic          reset, go, wbm_ack;
  logic [AW-1:0] wbm_address;
  logic [31:0]   wbm_writedata;
  logic          wbm_strobe, wbm_cycle, wbm_write;
  logic          busy, done, err;
  logic [3:0]    err_idx;

  always #5 clk = ~clk;

  sdram_cfg_master #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .go(go),
    .wbm_address(wbm_address), .wbm_writedata(wbm_writedata),
    .wbm_strobe(wbm_strobe), .wbm_cycle(wbm_cycle), .wbm_write(wbm_write),
    .wbm_ack(wbm_ack), .busy(busy), .done(done), .err(err), .err_idx(err_idx)
  );

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] exp_addr [10];
  logic [31:0]   exp_data [10];

  int lat_cfg [10];
  int never_idx, rst_at, extra;
  int go_at [3];
  bit spur;

  logic          stb_h [MAXC], cyc_h [MAXC], we_h [MAXC];
  logic          busy_h [MAXC], done_h [MAXC], err_h [MAXC];
  logic [3:0]    eidx_h [MAXC];
  logic [AW-1:0] addr_h [MAXC];
  logic [31:0]   data_h [MAXC];
  int            ncyc;
  logic [AW+41:0] rst_snap;

  int            run_start [16], run_len [16];
  logic [AW-1:0] run_addr [16];
  logic [31:0]   run_data [16];
  bit            run_stable [16];
  int            nruns;

  int exp_start [10];
  int exp_done;

  // Reference: write k starts after every earlier write's wait cycles plus REQ and GAP.
  function automatic void build_model();
    int acc = 0;
    for (int k = 0; k < 10; k++) begin
      exp_start[k] = acc;
      acc += lat_cfg[k] + 2;
    end
    exp_done = acc;
  endfunction

  function automatic void set_cfg(input int lat_all);
    for (int k = 0; k < 10; k++) lat_cfg[k] = lat_all;
    never_idx = -1; rst_at = -1; spur = 0; extra = 4;
    for (int i = 0; i < 3; i++) go_at[i] = -1;
  endfunction

  function automatic void extract_runs();
    logic prev = 1'b0;
    nruns = 0;
    for (int i = 0; i < 16; i++) begin
      run_start[i] = -1; run_len[i] = 0; run_stable[i] = 0;
      run_addr[i] = 'x; run_data[i] = 'x;
    end
    for (int c = 0; c < ncyc; c++) begin
      if (stb_h[c] === 1'b1) begin
        if (prev !== 1'b1) begin
          if (nruns < 16) begin
            run_start[nruns] = c; run_addr[nruns] = addr_h[c];
            run_data[nruns] = data_h[c]; run_stable[nruns] = 1;
          end
          nruns++;
        end
        if (nruns <= 16) begin
          run_len[nruns-1]++;
          if (addr_h[c] !== run_addr[nruns-1] || data_h[c] !== run_data[nruns-1] ||
              cyc_h[c] !== 1'b1 || we_h[c] !== 1'b1)
            run_stable[nruns-1] = 0;
        end
      end
      prev = stb_h[c];
    end
  endfunction

  // Pulses go (assumed called at a negedge), then acts as the slave cycle by cycle.
  task automatic run_seq();
    int k = 0, n = 0, tail = -1;
    for (int c = 0; c < MAXC; c++) begin
      stb_h[c] = 'x; cyc_h[c] = 'x; we_h[c] = 'x; busy_h[c] = 'x; done_h[c] = 'x;
      err_h[c] = 'x; eidx_h[c] = 'x; addr_h[c] = 'x; data_h[c] = 'x;
    end
    ncyc = 0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int c = 0; c < MAXC; c++) begin
      stb_h[c] = wbm_strobe; cyc_h[c] = wbm_cycle; we_h[c] = wbm_write;
      busy_h[c] = busy; done_h[c] = done; err_h[c] = err; eidx_h[c] = err_idx;
      addr_h[c] = wbm_address; data_h[c] = wbm_writedata;
      ncyc = c + 1;
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        rst_snap = {wbm_cycle, wbm_strobe, wbm_write, busy, done, err, err_idx,
                    wbm_address, wbm_writedata};
        wbm_ack = 1'b0; go = 1'b0;
        return;
      end
      wbm_ack = 1'b0;
      if (wbm_strobe === 1'b1) begin
        if (k < 10 && k != never_idx && n == lat_cfg[k]) begin
          wbm_ack = 1'b1; k++; n = 0;
        end else n++;
      end else if (spur) wbm_ack = 1'b1;
      go = 1'b0;
      for (int i = 0; i < 3; i++) if (go_at[i] == c) go = 1'b1;
      if (tail > 0) tail--;
      else if (tail < 0 && (done === 1'b1 || err === 1'b1)) tail = extra;
      if (tail == 0) break;
      @(negedge clk);
    end
    wbm_ack = 1'b0; go = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; wbm_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wbm_cycle, wbm_strobe, wbm_write, busy, done, err, err_idx, wbm_address, wbm_writedata} !== '0) begin
      errors++; $display("FAIL reset_outputs: cyc=%b stb=%b we=%b busy=%b done=%b err=%b, want all 0",
                         wbm_cycle, wbm_strobe, wbm_write, busy, done, err);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wbm_strobe, busy, done, err} !== 4'b0) begin
      errors++; $display("FAIL idle_after_reset: stb=%b busy=%b done=%b err=%b, want 0000",
                         wbm_strobe, busy, done, err);
    end
  endtask

  task automatic test_nominal();
    set_cfg(1);
    run_seq(); extract_runs();
    checks++;
    if (nruns != 10) begin errors++; $display("FAIL nominal_count: got %0d writes, want 10", nruns); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (run_start[k] != 3*k || run_len[k] != 2 || run_addr[k] !== exp_addr[k] ||
          run_data[k] !== exp_data[k] || !run_stable[k]) begin
        errors++;
        $display("FAIL nominal_w%0d: start=%0d len=%0d addr=%h data=%h stable=%0d, want start=%0d len=2 addr=%h data=%h stable=1",
                 k, run_start[k], run_len[k], run_addr[k], run_data[k], run_stable[k], 3*k, exp_addr[k], exp_data[k]);
      end
    end
    checks++;
    if ({done_h[29], done_h[30], busy_h[29], busy_h[30], err_h[30]} !== 5'b01100) begin
      errors++; $display("FAIL nominal_done: done29/30=%b%b busy29/30=%b%b err=%b, want 01 10 0",
                         done_h[29], done_h[30], busy_h[29], busy_h[30], err_h[30]);
    end
  endtask

  task automatic test_zero_wait();
    set_cfg(0);
    run_seq(); extract_runs();
    checks++;
    if (nruns != 10) begin errors++; $display("FAIL zero_count: got %0d writes, want 10", nruns); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (run_start[k] != 2*k || run_len[k] != 1 || run_addr[k] !== exp_addr[k] || run_data[k] !== exp_data[k]) begin
        errors++;
        $display("FAIL zero_w%0d: start=%0d len=%0d addr=%h data=%h, want start=%0d len=1 addr=%h data=%h",
                 k, run_start[k], run_len[k], run_addr[k], run_data[k], 2*k, exp_addr[k], exp_data[k]);
      end
    end
    checks++;
    if ({done_h[19], done_h[20], busy_h[20]} !== 3'b010) begin
      errors++; $display("FAIL zero_done: done19/20=%b%b busy20=%b, want 01 0", done_h[19], done_h[20], busy_h[20]);
    end
  endtask

  task automatic test_variable_latency();
    int rot [3] = '{0, 1, 5};
    int off;
    for (int it = 0; it < 4; it++) begin
      set_cfg(0);
      off = int'($urandom_range(0, 2));
      for (int k = 0; k < 10; k++)
        lat_cfg[k] = (it == 0) ? rot[(k + off) % 3] : int'($urandom_range(0, 6));
      build_model();
      run_seq(); extract_runs();
      checks++;
      if (nruns != 10) begin errors++; $display("FAIL varlat%0d_count: got %0d writes, want 10", it, nruns); end
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (run_start[k] != exp_start[k] || run_len[k] != lat_cfg[k] + 1 || run_addr[k] !== exp_addr[k] ||
            run_data[k] !== exp_data[k] || !run_stable[k] ||
            (k < 9 && run_start[k+1] - (run_start[k] + run_len[k]) != 1)) begin
          errors++;
          $display("FAIL varlat%0d_w%0d: start=%0d len=%0d addr=%h data=%h stable=%0d, want start=%0d len=%0d addr=%h data=%h stable=1 gap=1",
                   it, k, run_start[k], run_len[k], run_addr[k], run_data[k], run_stable[k],
                   exp_start[k], lat_cfg[k] + 1, exp_addr[k], exp_data[k]);
        end
      end
      checks++;
      if ({done_h[exp_done-1], done_h[exp_done], busy_h[exp_done], err_h[exp_done]} !== 4'b0100) begin
        errors++; $display("FAIL varlat%0d_done: at cycle %0d done(prev,now)=%b%b busy=%b err=%b, want 01 0 0",
                           it, exp_done, done_h[exp_done-1], done_h[exp_done], busy_h[exp_done], err_h[exp_done]);
      end
    end
  endtask

  task automatic test_timeout();
    int first_err = -1;
    set_cfg(1);
    never_idx = 3; extra = 20;
    run_seq(); extract_runs();
    for (int c = 0; c < ncyc; c++) if (first_err < 0 && err_h[c] === 1'b1) first_err = c;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (run_start[k] != 3*k || run_addr[k] !== exp_addr[k]) begin
        errors++; $display("FAIL timeout_pre_w%0d: start=%0d addr=%h, want start=%0d addr=%h",
                           k, run_start[k], run_addr[k], 3*k, exp_addr[k]);
      end
    end
    checks++;
    if (run_start[3] != 9 || run_len[3] != TMO) begin
      errors++; $display("FAIL timeout_stb_len: start=%0d len=%0d, want start=9 len=%0d", run_start[3], run_len[3], TMO);
    end
    checks++;
    if (first_err != 9 + TMO || stb_h[9+TMO] !== 1'b0 || eidx_h[9+TMO] !== 4'd3 || done_h[9+TMO] !== 1'b0) begin
      errors++; $display("FAIL timeout_err: err at %0d stb=%b err_idx=%0d done=%b, want err at %0d stb=0 err_idx=3 done=0",
                         first_err, stb_h[9+TMO], eidx_h[9+TMO], done_h[9+TMO], 9 + TMO);
    end
    checks++;
    if (nruns != 4 || err_h[ncyc-1] !== 1'b1 || busy_h[ncyc-1] !== 1'b0) begin
      errors++; $display("FAIL timeout_quiet: writes=%0d err_end=%b busy_end=%b, want 4 1 0",
                         nruns, err_h[ncyc-1], busy_h[ncyc-1]);
    end
    set_cfg(1);
    run_seq(); extract_runs();
    checks++;
    if (err_h[0] !== 1'b0 || eidx_h[0] !== 4'd0 || busy_h[0] !== 1'b1) begin
      errors++; $display("FAIL timeout_recover_clear: err=%b err_idx=%0d busy=%b, want 0 0 1", err_h[0], eidx_h[0], busy_h[0]);
    end
    checks++;
    if (nruns != 10 || run_start[9] != 27 || done_h[30] !== 1'b1 || err_h[30] !== 1'b0) begin
      errors++; $display("FAIL timeout_recover_run: writes=%0d last_start=%0d done30=%b err30=%b, want 10 27 1 0",
                         nruns, run_start[9], done_h[30], err_h[30]);
    end
  endtask

  task automatic test_ignored_go();
    set_cfg(1);
    go_at[0] = 5; go_at[1] = 19; go_at[2] = 20;
    run_seq(); extract_runs();
    checks++;
    if (nruns != 10) begin errors++; $display("FAIL igngo_count: got %0d writes, want 10", nruns); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (run_start[k] != 3*k || run_addr[k] !== exp_addr[k] || run_data[k] !== exp_data[k]) begin
        errors++; $display("FAIL igngo_w%0d: start=%0d addr=%h data=%h, want start=%0d addr=%h data=%h",
                           k, run_start[k], run_addr[k], run_data[k], 3*k, exp_addr[k], exp_data[k]);
      end
    end
    checks++;
    if ({done_h[29], done_h[30], busy_h[30]} !== 3'b010) begin
      errors++; $display("FAIL igngo_done: done29/30=%b%b busy30=%b, want 01 0", done_h[29], done_h[30], busy_h[30]);
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(1);
    rst_at = 18;
    run_seq();
    checks++;
    if (stb_h[18] !== 1'b1 || addr_h[18] !== exp_addr[6]) begin
      errors++; $display("FAIL rstmid_pre: stb=%b addr=%h, want 1 %h", stb_h[18], addr_h[18], exp_addr[6]);
    end
    checks++;
    if (rst_snap !== '0) begin
      errors++; $display("FAIL rstmid_async: outputs=%h, want 0", rst_snap);
    end
    #2 reset = 1'b0;
    @(negedge clk);
    set_cfg(1);
    run_seq(); extract_runs();
    checks++;
    if (nruns != 10 || run_start[0] != 0 || run_addr[0] !== exp_addr[0] || run_data[0] !== exp_data[0] ||
        run_addr[9] !== exp_addr[9] || done_h[30] !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart: writes=%0d start0=%0d addr0=%h data0=%h addr9=%h done30=%b, want 10 0 %h %h %h 1",
                         nruns, run_start[0], run_addr[0], run_data[0], run_addr[9], done_h[30],
                         exp_addr[0], exp_data[0], exp_addr[9]);
    end
  endtask

  task automatic test_spurious_ack();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wbm_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({wbm_strobe, wbm_cycle, busy, done, err} !== 5'b0) begin
        errors++; $display("FAIL spur_idle%0d: stb=%b cyc=%b busy=%b done=%b err=%b, want 00000",
                           i, wbm_strobe, wbm_cycle, busy, done, err);
      end
    end
    wbm_ack = 1'b0;
    set_cfg(1);
    spur = 1; extra = 8;
    run_seq(); extract_runs();
    checks++;
    if (nruns != 10) begin errors++; $display("FAIL spur_count: got %0d writes, want 10", nruns); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (run_start[k] != 3*k || run_len[k] != 2 || run_addr[k] !== exp_addr[k] || run_data[k] !== exp_data[k]) begin
        errors++; $display("FAIL spur_gap_w%0d: start=%0d len=%0d addr=%h data=%h, want start=%0d len=2 addr=%h data=%h",
                           k, run_start[k], run_len[k], run_addr[k], run_data[k], 3*k, exp_addr[k], exp_data[k]);
      end
    end
    for (int c = 30; c < ncyc; c++) begin
      checks++;
      if (done_h[c] !== 1'b1 || stb_h[c] !== 1'b0 || busy_h[c] !== 1'b0) begin
        errors++; $display("FAIL spur_done_c%0d: done=%b stb=%b busy=%b, want 1 0 0", c, done_h[c], stb_h[c], busy_h[c]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_addr = '{16'h04, 16'h08, 16'h0c, 16'h10, 16'h14, 16'h18, 16'h1c, 16'h20, 16'h24, 16'h00};
    exp_data = '{32'h230, 32'h0, 32'd10000, 32'd2, 32'd7, 32'd782, 32'd2, 32'd2, 32'd2, 32'h1};
    @(negedge clk);
    test_reset();
    test_nominal();
    test_zero_wait();
    test_variable_latency();
    test_timeout();
    test_ignored_go();
    test_reset_mid();
    test_spurious_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
